// File: rtl/fp_norm_pkg.sv
// ============================================================================
// Module : fp_norm_pkg
// Brief  : Shared types, constants and helpers for the fp_norm_seq normalizer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } norm_state_t;

  localparam int BYTE_W = 8;

  // Shift distance limited by the exponent so the result degrades to a denormal.
  function automatic logic [31:0] clamp_shift(input logic [31:0] lz, input logic [31:0] exp_v);
    return (lz < exp_v) ? lz : exp_v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_norm_seq_lzc8.sv
// ============================================================================
// Module : lzc_8
// Brief  : 8-bit leading-zero counter; o_valid flags a nonzero byte.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzc_8 (
  input  logic [7:0] i_data,
  output logic [2:0] o_cnt,
  output logic       o_valid
);

  always_comb begin
    o_cnt   = 3'd0;
    o_valid = |i_data;
    // Ascending scan: the highest set bit writes last and wins.
    for (int i = 0; i < 8; i++) begin
      if (i_data[i]) o_cnt = 3'(7 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_norm_seq.sv
// ============================================================================
// Module : fp_norm_seq
// Brief  : Multi-cycle mantissa normalizer, one byte scanned per cycle with a
//          shared lzc_8. Optional FP_NORM_BYPASS_EN skips already-normal inputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_norm_seq
  import fp_norm_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int EXP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_mant,
  input  logic [EXP_W-1:0]           in_exp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_mant,
  output logic [EXP_W-1:0]           out_exp,
  output logic [$clog2(WIDTH+1)-1:0] out_lz,
  output logic                       out_zero,
  output logic                       busy
);

  localparam int NB  = WIDTH / BYTE_W;
  localparam int LZW = $clog2(WIDTH + 1);
  localparam int KW  = (NB > 1) ? $clog2(NB) : 1;

  norm_state_t      r_state;
  logic [WIDTH-1:0] r_mant;
  logic [EXP_W-1:0] r_exp;
  logic [KW-1:0]    r_k;
  logic [LZW-1:0]   r_lz;

  logic [WIDTH-1:0] r_out_mant;
  logic [EXP_W-1:0] r_out_exp;
  logic [LZW-1:0]   r_out_lz;
  logic             r_out_zero;
  logic             r_out_valid;

  logic [7:0]       w_byte;
  logic [2:0]       w_c;
  logic             w_v;
  logic [LZW-1:0]   w_sh;
  logic             w_accept;

  always_comb begin
    w_byte = 8'd0;
    for (int i = 0; i < NB; i++) begin
      if (r_k == KW'(i)) w_byte = r_mant[WIDTH-1-BYTE_W*i -: BYTE_W];
    end
  end

  lzc_8 u_lzc (
    .i_data  (w_byte),
    .o_cnt   (w_c),
    .o_valid (w_v)
  );

  assign w_sh     = LZW'(clamp_shift(32'(r_lz), 32'(r_exp)));
  assign w_accept = in_valid && (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mant      <= '0;
      r_exp       <= '0;
      r_k         <= '0;
      r_lz        <= '0;
      r_out_mant  <= '0;
      r_out_exp   <= '0;
      r_out_lz    <= '0;
      r_out_zero  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mant  <= in_mant;
            r_exp   <= in_exp;
            r_k     <= '0;
            r_lz    <= '0;
            r_state <= SCAN;
`ifdef FP_NORM_BYPASS_EN
            if (in_mant[WIDTH-1]) begin
              r_out_mant  <= in_mant;
              r_out_exp   <= in_exp;
              r_out_lz    <= '0;
              r_out_zero  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
`endif
          end
        end
        SCAN: begin
          if (w_v) begin
            r_lz    <= r_lz + LZW'(w_c);
            r_state <= SHIFT;
          end else if (r_k != KW'(NB - 1)) begin
            r_lz <= r_lz + LZW'(BYTE_W);
            r_k  <= r_k + KW'(1);
          end else begin
            r_lz        <= LZW'(WIDTH);
            r_out_lz    <= LZW'(WIDTH);
            r_out_zero  <= 1'b1;
            r_out_mant  <= '0;
            r_out_exp   <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        SHIFT: begin
          r_out_mant  <= r_mant << w_sh;
          r_out_exp   <= r_exp - EXP_W'(w_sh);
          r_out_lz    <= r_lz;
          r_out_zero  <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out_mant  = r_out_mant;
  assign out_exp   = r_out_exp;
  assign out_lz    = r_out_lz;
  assign out_zero  = r_out_zero;

endmodule

`default_nettype wire

// File: tb/tb_fp_norm_seq.sv
// ============================================================================
// Module : tb_fp_norm_seq
// Brief  : Directed self-checking bench for fp_norm_seq (WIDTH=24, EXP_W=8).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_norm_seq;

  localparam int WIDTH = 24;
  localparam int EXP_W = 8;
  localparam int LZW   = $clog2(WIDTH + 1);

`ifdef FP_NORM_BYPASS_EN
  localparam int BYP_LAT = 1;
`else
  localparam int BYP_LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mant;
  logic [EXP_W-1:0] in_exp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic [LZW-1:0]   out_lz;
  logic             out_zero;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_norm_seq #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_lz    (out_lz),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand and return the cycle count from the accept cycle to out_valid.
  task automatic send(input logic [WIDTH-1:0] m, input logic [EXP_W-1:0] e, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("in_ready_before_send", 64'(in_ready), 64'd1);
    in_mant  = m;
    in_exp   = e;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", 64'(out_valid), 64'd0);
    chk("release_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic op(input string name, input logic [WIDTH-1:0] m, input logic [EXP_W-1:0] e,
                    input logic [WIDTH-1:0] w_m, input logic [EXP_W-1:0] w_e,
                    input int w_lz, input logic w_z, input int w_lat);
    int lat;
    send(m, e, lat);
    $display("[TB] vector %s", name);
    chk("latency",  64'(lat),       64'(w_lat));
    chk("out_mant", 64'(out_mant),  64'(w_m));
    chk("out_exp",  64'(out_exp),   64'(w_e));
    chk("out_lz",   64'(out_lz),    64'(w_lz));
    chk("out_zero", 64'(out_zero),  64'(w_z));
    release_out();
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready),  64'd1);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_mant",  64'(out_mant),  64'd0);
    chk("rst_exp",   64'(out_exp),   64'd0);
    chk("rst_lz",    64'(out_lz),    64'd0);
    chk("rst_zero",  64'(out_zero),  64'd0);
    rst_n = 1'b1;
    tick();

    op("mid_byte",   24'h004000, 8'd100, 24'h800000, 8'd91,  9,  1'b0, 4);
    op("all_zero",   24'h000000, 8'd50,  24'h000000, 8'd0,   24, 1'b1, 4);
    op("exp_clamp",  24'h000001, 8'd5,   24'h000020, 8'd0,   23, 1'b0, 5);
    op("last_byte",  24'h000080, 8'd100, 24'h800000, 8'd84,  16, 1'b0, 5);
    op("top_byte",   24'h123456, 8'd3,   24'h91A2B0, 8'd0,   3,  1'b0, 3);
    op("clamp_one",  24'h3FFFFF, 8'd1,   24'h7FFFFE, 8'd0,   2,  1'b0, 3);
    op("exp_eq_lz",  24'h0000FF, 8'd16,  24'hFF0000, 8'd0,   16, 1'b0, 5);
    op("bypass",     24'h800000, 8'd10,  24'h800000, 8'd10,  0,  1'b0, BYP_LAT);

    // Backpressure: hold DONE, poke in_valid with other data, outputs must not move.
    send(24'h004000, 8'd100, lat);
    chk("bp_latency", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_mant  = 24'h000001;
      in_exp   = 8'd7;
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_ready", 64'(in_ready),  64'd0);
      chk("bp_mant",  64'(out_mant),  64'h800000);
      chk("bp_exp",   64'(out_exp),   64'd91);
      chk("bp_lz",    64'(out_lz),    64'd9);
    end
    in_valid = 1'b0;
    release_out();
    chk("bp_idle_busy", 64'(busy), 64'd0);

    // Reset during SCAN of a long scan; reset takes effect without a clock edge.
    in_mant  = 24'h000001;
    in_exp   = 8'd40;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready),  64'd1);
    chk("midrst_busy",  64'(busy),      64'd0);
    chk("midrst_lz",    64'(out_lz),    64'd0);
    #1;
    rst_n = 1'b1;
    tick();
    op("after_rst",  24'h010000, 8'd20,  24'h800000, 8'd13,  7,  1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/fp_norm_seq.md
Name: fp_norm_seq

Overview:
Multi-cycle mantissa normalizer for the FP datapath. It scans a WIDTH-bit mantissa one byte per cycle, MSB byte first, using a single shared 8-bit leading-zero counter (lzc_8). It then left-shifts the mantissa and adjusts the exponent in one cycle. It sits after the add/sub alignment stage and before rounding. Valid/ready handshake on both sides.

Parameters:
WIDTH, 24, mantissa width in bits; must be a multiple of 8 and at least 8; NB = WIDTH/8.
EXP_W, 8, exponent width in bits.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input operand valid
in_ready  output  1  block can accept an operand
in_mant  input  WIDTH  unnormalized mantissa
in_exp  input  EXP_W  unbiased-free exponent, unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_mant  output  WIDTH  normalized mantissa
out_exp  output  EXP_W  adjusted exponent
out_lz  output  $clog2(WIDTH+1)  raw leading-zero count of in_mant
out_zero  output  1  in_mant was all zeros
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - out_valid = 0, out_mant = 0, out_exp = 0, out_lz = 0, out_zero = 0.
  - in_ready = 1, busy = 0.
- Handshake and states:
  - in_ready = (state == IDLE).
  - Accept when in_valid && in_ready. in_mant and in_exp are registered and the byte index k is cleared to 0.
  - States: IDLE, SCAN, SHIFT, DONE.
  - IDLE -> SCAN on accept.
- SCAN (one byte per cycle):
  - Byte k = mant[WIDTH-1-8k -: 8] is fed to lzc_8 (c = leading zeros within the byte, v = byte nonzero).
  - v = 1: lz += c, go to SHIFT.
  - v = 0 and k < NB-1: lz += 8, k++.
  - v = 0 and k = NB-1: lz = WIDTH, out_zero = 1, out_mant = 0, out_exp = 0, go to DONE.
  - The c output of lzc_8 is ignored when v = 0.
- SHIFT (exactly one cycle):
  - sh = min(lz, in_exp).
  - out_mant = mant << sh; out_exp = in_exp - sh; out_lz = lz.
  - This clamps to a denormal when in_exp is smaller than lz. The exponent never wraps below 0.
- DONE:
  - out_valid = 1. All outputs are held stable until out_ready.
  - On out_valid && out_ready: go to IDLE and clear out_valid.
  - A new accept is possible the following cycle; no same-cycle turnaround.
- Latency (accept cycle = T, first nonzero byte index = k):
  - Nonzero input: SCAN cycles T+1..T+1+k, SHIFT at T+2+k, out_valid at T+3+k.
  - All-zero input: out_valid at T+1+NB.
- Boundary conditions:
  - Only one operand is in flight; in_valid is ignored while busy.
  - rst_n asserted in any state returns immediately to reset values. Any in-flight operand is discarded.
  - lz counter width is $clog2(WIDTH+1) and does not overflow.

Optional Feature:
Macro FP_NORM_BYPASS_EN.
- Defined: on accept, if in_mant[WIDTH-1] = 1 the block goes directly to DONE. out_mant = in_mant, out_exp = in_exp, out_lz = 0, out_valid at T+1.
- Undefined: no bypass. Such an input takes the normal path with k = 0, out_valid at T+3.

Decomposition:
- Shared package fp_norm_pkg holds:
  - typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} norm_state_t.
  - localparam BYTE_W = 8.
  - Helper function clamp_shift(lz, exp).
- Single sub-module instance: the existing lzc_8, time-multiplexed across bytes.
- No further hierarchy.

Test Plan:
- Mid-byte leading one (WIDTH=24): in_mant=0x004000, in_exp=100 -> out_lz=9, out_mant=0x800000, out_exp=91, out_valid at T+4.
- All-zero input: in_mant=0x000000, in_exp=50 -> out_zero=1, out_lz=24, out_mant=0, out_exp=0, out_valid at T+4.
- Exponent clamp: in_mant=0x000001, in_exp=5 -> out_lz=23, out_mant=0x000020, out_exp=0.
- Backpressure: out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored. Release -> IDLE next cycle, in_ready=1.
- Reset mid-operation: rst_n low during SCAN -> out_valid=0, in_ready=1 immediately. A subsequent in_mant=0x010000 gives out_lz=7.
- Bypass: in_mant=0x800000, in_exp=10.
  - With FP_NORM_BYPASS_EN: out_valid at T+1, out_lz=0.
  - Without it: out_valid at T+3, identical data.
